// File: rtl/srl_fifo_wxd_pkg.sv
// srl_fifo_wxd_pkg
//   Shared type definitions for the SRL FIFO slice.
//   It holds only the encoding of where the output register takes its next value from.
//   Sizes such as DEPTH and the count width are derived locally inside each module.
package srl_fifo_wxd_pkg;

    // Source selected for the output register on a given cycle
    typedef enum logic [1:0] {
        OUT_HOLD       = 2'd0,  // register not loading; keep current word
        OUT_FROM_ARRAY = 2'd1,  // load the oldest word of the shift array
        OUT_BYPASS     = 2'd2,  // array empty: take in_data straight through
        OUT_EMPTY      = 2'd3   // nothing to load; output becomes invalid
    } out_src_e;

endpackage

// File: rtl/srl_fifo_wxd_if.sv
// srl_fifo_wxd_if
//   Valid/ready stream bundle used on both sides of the FIFO.
//   Ports (signals):
//     valid  producer has a word on data
//     ready  consumer accepts the word this cycle
//     data   DATA_WIDTH payload
//   Modports:
//     master  drives valid/data, samples ready (FIFO output side)
//     slave   samples valid/data, drives ready (FIFO input side)
interface srl_fifo_wxd_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  valid;
    logic                  ready;
    logic [DATA_WIDTH-1:0] data;

    modport master (output valid, output data, input  ready);
    modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/srl_fifo_wxd_shift_array.sv
// srl_shift_array
//   Clock-enabled shift register of DEPTH words with an addressed asynchronous read.
//   Written so that synthesis can map each bit column onto SRL16/SRLC32 LUTs,
//   which is why there is no reset on the storage.
//   Ports:
//     clk   clock
//     en    shift enable: din enters word 0, every word moves one place up
//     din   DATA_WIDTH word shifted in
//     addr  DEPTH_LOG2 read address
//     dout  DATA_WIDTH word at addr (combinational)
module srl_shift_array #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DEPTH_LOG2-1:0] addr,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DATA_WIDTH-1:0] arr_q [DEPTH];
    logic [DATA_WIDTH-1:0] arr_d [DEPTH];

    // Next array contents: newest word at index 0, older words move toward DEPTH-1
    always_comb begin
        arr_d = arr_q;
        if (en) begin
            arr_d[0] = din;
            for (int i = 1; i < DEPTH; i++) begin
                arr_d[i] = arr_q[i-1];
            end
        end
    end

    // Storage has no reset so it stays mappable to shift-register LUTs
    always_ff @(posedge clk) begin
        arr_q <= arr_d;
    end

    assign dout = arr_q[addr];

endmodule

// File: rtl/srl_fifo_wxd.sv
// srl_fifo_wxd
//   SRL-style FIFO with valid/ready on both sides, fill level, almost_full and an
//   optional output register. Words shift into srl_shift_array; the oldest word
//   sits at index cnt-1.
//   Parameters:
//     DATA_WIDTH   word width
//     DEPTH_LOG2   log2 of shift-array depth (1..6)
//     AFULL_LEVEL  almost_full threshold on fill (1..DEPTH+OUT_REG)
//     OUT_REG      1: registered output stage, capacity DEPTH+1; 0: direct array read
//   Ports:
//     clk          clock, all logic on posedge
//     rst_n        asynchronous active-low reset
//     clr          synchronous flush, overrides push/pop
//     in_if        slave stream: in_valid / in_ready / in_data
//     out_if       master stream: out_valid / out_ready / out_data (first-word-fall-through)
//     fill         words held, including the output register
//     almost_full  fill >= AFULL_LEVEL
module srl_fifo_wxd
    import srl_fifo_wxd_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int DEPTH_LOG2  = 4,
    parameter int AFULL_LEVEL = 12,
    parameter int OUT_REG     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    srl_fifo_wxd_if.slave         in_if,
    srl_fifo_wxd_if.master        out_if,
    output logic [DEPTH_LOG2:0]   fill,
    output logic                  almost_full
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_LEVEL);

    // Elaboration-time parameter range checks
    if (DEPTH_LOG2 < 1 || DEPTH_LOG2 > 6) begin : g_bad_depth
        $error("srl_fifo_wxd: DEPTH_LOG2 out of range 1..6");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH + ((OUT_REG != 0) ? 1 : 0)) begin : g_bad_afull
        $error("srl_fifo_wxd: AFULL_LEVEL out of range 1..DEPTH+OUT_REG");
    end

    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]      fill_q, fill_d;
    logic                  almost_full_q, almost_full_d;

    logic                  in_ready;
    logic                  out_valid;
    logic                  push;
    logic                  pop;
    logic                  out_load;
    logic                  shift_en;
    out_src_e              out_src;
    logic [DEPTH_LOG2-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    // Address of the oldest word, taken from the count before this cycle's shift
    assign rd_addr  = cnt_q[DEPTH_LOG2-1:0] - DEPTH_LOG2'(1);

    // in_ready depends only on the registered count, never on out_ready
    assign in_ready  = (cnt_q < DEPTH_C);
    assign out_valid = (OUT_REG != 0) ? out_valid_q : (cnt_q != '0);
    assign push      = in_if.valid & in_ready;
    assign pop       = out_valid & out_if.ready;
    assign out_load  = ~out_valid_q | out_if.ready;

    srl_shift_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .en   (shift_en),
        .din  (in_if.data),
        .addr (rd_addr),
        .dout (rd_data)
    );

    // Next-state for count, output stage and shift enable
    always_comb begin
        out_src     = OUT_HOLD;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        shift_en    = 1'b0;

        if (OUT_REG != 0) begin
            if (out_load) begin
                if (cnt_q != '0) begin
                    out_src = OUT_FROM_ARRAY;
                end else if (push) begin
                    out_src = OUT_BYPASS;
                end else begin
                    out_src = OUT_EMPTY;
                end
            end

            case (out_src)
                OUT_FROM_ARRAY: begin
                    // Head leaves the array; a simultaneous push refills it (net 0)
                    out_valid_d = 1'b1;
                    shift_en    = push;
                    cnt_d       = push ? cnt_q : cnt_q - CNT_W'(1);
                end
                OUT_BYPASS: begin
                    // Empty array: word goes straight to the output register
                    out_valid_d = 1'b1;
                end
                OUT_EMPTY: begin
                    out_valid_d = 1'b0;
                end
                default: begin
                    shift_en = push;
                    cnt_d    = push ? cnt_q + CNT_W'(1) : cnt_q;
                end
            endcase
        end else begin
            shift_en    = push;
            out_valid_d = 1'b0;
            if (push && !pop) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (pop && !push) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end

        // Flush wins over everything, including the word offered this cycle
        if (clr) begin
            out_src     = OUT_HOLD;
            cnt_d       = '0;
            out_valid_d = 1'b0;
            shift_en    = 1'b0;
        end
    end

    // Output data and status next-state
    always_comb begin
        case (out_src)
            OUT_FROM_ARRAY: out_data_d = rd_data;
            OUT_BYPASS:     out_data_d = in_if.data;
            default:        out_data_d = out_data_q;
        endcase
        fill_d        = cnt_d + CNT_W'(((OUT_REG != 0) && out_valid_d) ? 1 : 0);
        almost_full_d = (fill_d >= AFULL_C);
    end

    // Control state, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q         <= '0;
            out_valid_q   <= 1'b0;
            fill_q        <= '0;
            almost_full_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            out_valid_q   <= out_valid_d;
            fill_q        <= fill_d;
            almost_full_q <= almost_full_d;
        end
    end

    // Output word is don't-care while out_valid is low, so it carries no reset
    always_ff @(posedge clk) begin
        out_data_q <= out_data_d;
    end

    assign in_if.ready  = in_ready;
    assign out_if.valid = out_valid;
    assign out_if.data  = (OUT_REG != 0) ? out_data_q : rd_data;
    assign fill         = fill_q;
    assign almost_full  = almost_full_q;

endmodule
